// File: rtl/enemy_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : enemy_scheduler_pkg                                             |
// | Brief    : Shared game-lane constants, spawn FSM encodings, helpers.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package enemy_scheduler_pkg;

    localparam int unsigned c_pos_w        = 4;
    localparam int unsigned c_pos_max_dflt = 10;
    localparam int unsigned c_led_w        = 11;
    localparam int unsigned c_esc_w        = 8;
    localparam int unsigned c_gap_w        = 4;
    localparam int unsigned c_cnt_w        = 4;

    typedef logic [0:0] spawn_state_t;
    localparam spawn_state_t c_st_wait  = 1'b0;
    localparam spawn_state_t c_st_ready = 1'b1;

    // Escape total sticks at all-ones instead of wrapping.
    function automatic logic [c_esc_w-1:0] sat_add(input logic [c_esc_w-1:0] a,
                                                   input logic [c_cnt_w-1:0] b);
        logic [c_esc_w:0] s;
        s = {1'b0, a} + {{(c_esc_w + 1 - c_cnt_w){1'b0}}, b};
        return s[c_esc_w] ? {c_esc_w{1'b1}} : s[c_esc_w-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_scheduler_lfsr8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lfsr8                                                           |
// | Brief    : 8-bit Fibonacci LFSR (taps 8,6,5,4), advances only when en.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= seed;
        end else if (en) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/enemy_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : enemy_scheduler                                                 |
// | Brief    : Multi-enemy lane sequencer: advance, escape, spawn and kill.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module enemy_scheduler
    import enemy_scheduler_pkg::*;
#(
    parameter int         NUM_ENEMY = 4,
    parameter int         POS_MAX   = c_pos_max_dflt,
    parameter int         SPAWN_GAP = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step,
    input  logic                          kill,
    input  logic [$clog2(NUM_ENEMY)-1:0]  kill_slot,
    output logic [c_pos_w*NUM_ENEMY-1:0]  pos,
    output logic [NUM_ENEMY-1:0]          alive,
    output logic                          escape,
    output logic [c_esc_w-1:0]            escape_cnt,
    output logic [POS_MAX:0]              occupancy
);

    localparam int                 c_slot_w   = $clog2(NUM_ENEMY);
    localparam logic [c_pos_w-1:0] c_pos_last = c_pos_w'(POS_MAX);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(SPAWN_GAP);

    logic [c_pos_w-1:0]  r_pos [NUM_ENEMY];
    logic [NUM_ENEMY-1:0] r_alive;
    logic                r_escape;
    logic [c_esc_w-1:0]  r_escape_cnt;
    spawn_state_t        r_state;
    spawn_state_t        w_state_nxt;
    logic [c_gap_w-1:0]  r_gap;
    logic [c_gap_w-1:0]  w_gap_nxt;

    logic [NUM_ENEMY-1:0] w_kill_hit;
    logic [c_cnt_w-1:0]   w_esc_n;
    logic                 w_free_any;
    logic [c_slot_w-1:0]  w_spawn_slot;
    logic                 w_spawn;
    logic [7:0]           w_lfsr_q;
    logic [POS_MAX:0]     w_occ;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (step),
        .seed (LFSR_SEED),
        .q    (w_lfsr_q)
    );

    // Out-of-range kill_slot values match no slot and are therefore ignored.
    generate
        for (genvar i = 0; i < NUM_ENEMY; i++) begin : g_slot
            assign w_kill_hit[i]              = kill && (32'(kill_slot) == i);
            assign pos[c_pos_w*i +: c_pos_w] = r_pos[i];
        end
    endgenerate

    // Free-slot search and escape count both look at state before the edge.
    always_comb begin
        w_esc_n      = '0;
        w_free_any   = 1'b0;
        w_spawn_slot = '0;
        for (int i = NUM_ENEMY - 1; i >= 0; i--) begin
            if (!r_alive[i]) begin
                w_free_any   = 1'b1;
                w_spawn_slot = c_slot_w'(i);
            end
        end
        for (int i = 0; i < NUM_ENEMY; i++) begin
            if (step && r_alive[i] && !w_kill_hit[i] && (r_pos[i] == c_pos_last)) begin
                w_esc_n = w_esc_n + c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_spawn     = 1'b0;
        case (r_state)
            c_st_wait: begin
                if (step) begin
                    w_gap_nxt = r_gap + c_gap_w'(1);
                    if (w_gap_nxt == c_gap_last) begin
                        w_state_nxt = c_st_ready;
                    end
                end
            end
            c_st_ready: begin
                if (step && w_lfsr_q[0] && w_free_any) begin
                    w_spawn     = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = c_st_wait;
                end
            end
            default: w_state_nxt = c_st_wait;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_wait;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Spawn only ever targets a dead slot, so it can take priority safely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENEMY; i++) begin
                r_pos[i] <= '0;
            end
            r_alive <= '0;
        end else begin
            for (int i = 0; i < NUM_ENEMY; i++) begin
                if (w_spawn && (w_spawn_slot == c_slot_w'(i))) begin
                    r_pos[i]   <= '0;
                    r_alive[i] <= 1'b1;
                end else if (w_kill_hit[i]) begin
                    r_alive[i] <= 1'b0;
                end else if (step && r_alive[i]) begin
                    if (r_pos[i] == c_pos_last) begin
                        r_alive[i] <= 1'b0;
                    end else begin
                        r_pos[i] <= r_pos[i] + c_pos_w'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_escape     <= 1'b0;
            r_escape_cnt <= '0;
        end else begin
            r_escape     <= (w_esc_n != '0);
            r_escape_cnt <= sat_add(r_escape_cnt, w_esc_n);
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < NUM_ENEMY; i++) begin
            if (r_alive[i] && (r_pos[i] <= c_pos_last)) begin
                w_occ[r_pos[i]] = 1'b1;
            end
        end
    end

    assign alive      = r_alive;
    assign escape     = r_escape;
    assign escape_cnt = r_escape_cnt;
    assign occupancy  = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_enemy_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_enemy_scheduler                                              |
// | Brief    : Scoreboard bench for enemy_scheduler with a behavioural model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_enemy_scheduler;

    localparam int         NE   = 4;
    localparam int         PMAX = 10;
    localparam int         GAP  = 1;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  kill_slot = 2'd0;
    logic [15:0] pos;
    logic [3:0]  alive;
    logic        escape;
    logic [7:0]  escape_cnt;
    logic [10:0] occupancy;

    always #5 clk = ~clk;

    enemy_scheduler #(
        .NUM_ENEMY (NE),
        .POS_MAX   (PMAX),
        .SPAWN_GAP (GAP),
        .LFSR_SEED (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .kill       (kill),
        .kill_slot  (kill_slot),
        .pos        (pos),
        .alive      (alive),
        .escape     (escape),
        .escape_cnt (escape_cnt),
        .occupancy  (occupancy)
    );

    typedef struct packed {
        logic [15:0] pos;
        logic [3:0]  alive;
        logic        esc;
        logic [7:0]  cnt;
        logic [10:0] occ;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    int       m_pos [NE];
    bit       m_alive [NE];
    bit [7:0] m_lfsr;
    int       m_gap;
    bit       m_ready;
    bit       m_esc;
    int       m_cnt;
    int       m_total_esc;

    // Spawn spacing observed on the DUT
    logic [3:0] prev_alive = 4'd0;
    int         steps_since = 1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_pos[i]   = 0;
            m_alive[i] = 1'b0;
        end
        m_lfsr  = SEED;
        m_gap   = 0;
        m_ready = 1'b0;
        m_esc   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input bit s, input bit k, input int ks);
        int n_pos [NE];
        bit n_alive [NE];
        int n = 0;
        int f = -1;
        for (int i = 0; i < NE; i++) begin
            n_pos[i]   = m_pos[i];
            n_alive[i] = m_alive[i];
        end
        for (int i = 0; i < NE; i++) begin
            if (k && ks == i) n_alive[i] = 1'b0;
            else if (s && m_alive[i]) begin
                if (m_pos[i] == PMAX) begin
                    n_alive[i] = 1'b0;
                    n++;
                end else begin
                    n_pos[i] = m_pos[i] + 1;
                end
            end
        end
        if (s) begin
            if (!m_ready) begin
                m_gap++;
                if (m_gap == GAP) m_ready = 1'b1;
            end else begin
                for (int i = NE - 1; i >= 0; i--) if (!m_alive[i]) f = i;
                if (m_lfsr[0] && f >= 0) begin
                    n_alive[f] = 1'b1;
                    n_pos[f]   = 0;
                    m_gap      = 0;
                    m_ready    = 1'b0;
                end
            end
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
        m_esc = (n != 0);
        m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
        m_total_esc += n;
        for (int i = 0; i < NE; i++) begin
            m_pos[i]   = n_pos[i];
            m_alive[i] = n_alive[i];
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e = '0;
        for (int i = 0; i < NE; i++) begin
            e.pos[4*i +: 4] = 4'(m_pos[i]);
            e.alive[i]      = m_alive[i];
            if (m_alive[i]) e.occ[m_pos[i]] = 1'b1;
        end
        e.esc = m_esc;
        e.cnt = 8'(m_cnt);
        return e;
    endfunction

    function automatic bit model_full();
        bit r = 1'b1;
        for (int i = 0; i < NE; i++) r &= m_alive[i];
        return r;
    endfunction

    task automatic cycle(input bit s, input bit k, input int ks);
        exp_t       e;
        logic [3:0] born;
        @(negedge clk);
        step      = s;
        kill      = k;
        kill_slot = 2'(ks);
        model_step(s, k, ks);
        sb_q.push_back(model_exp());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("pos", 32'(pos), 32'(e.pos));
        check("alive", 32'(alive), 32'(e.alive));
        check("escape", 32'(escape), 32'(e.esc));
        check("escape_cnt", 32'(escape_cnt), 32'(e.cnt));
        check("occupancy", 32'(occupancy), 32'(e.occ));
        if (s) steps_since++;
        born = alive & ~prev_alive;
        if (born != 4'd0) begin
            check("spawn_spacing_ok", 32'(steps_since >= GAP), 32'd1);
            steps_since = 0;
        end
        prev_alive = alive;
        step = 1'b0;
        kill = 1'b0;
    endtask

    initial begin
        int  idx;
        int  cnt_before;
        bit  got;
        m_total_esc = 0;
        model_reset();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_alive", 32'(alive), 32'd0);
        check("rst_escape", 32'(escape), 32'd0);
        check("rst_cnt", 32'(escape_cnt), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        @(negedge clk) rst = 1'b1;

        // Single traversal of slot 0
        for (int t = 0; t < 200 && !m_alive[0]; t++) cycle(1'b1, 1'b0, 0);
        check("first_spawn_slot0", 32'(alive[0]), 32'd1);
        repeat (10) cycle(1'b1, 1'b0, 0);
        check("trav_pos10", 32'(pos[3:0]), 32'd10);
        check("trav_occ_bit10", 32'(occupancy[10]), 32'd1);
        cycle(1'b1, 1'b0, 0);
        check("trav_alive0", 32'(alive[0]), 32'd0);
        check("trav_escape", 32'(escape), 32'd1);
        check("trav_cnt", 32'(escape_cnt), 32'd1);
        cycle(1'b0, 1'b0, 0);
        check("escape_one_cycle", 32'(escape), 32'd0);

        // Kill and step on a slot sitting at the last position
        idx = -1;
        for (int t = 0; t < 300 && idx < 0; t++) begin
            for (int i = 0; i < NE; i++) if (m_alive[i] && m_pos[i] == PMAX) idx = i;
            if (idx < 0) cycle(1'b1, 1'b0, 0);
        end
        got = (idx >= 0);
        check("kill_race_found", 32'(got), 32'd1);
        if (idx >= 0) begin
            cnt_before = m_cnt;
            cycle(1'b1, 1'b1, idx);
            check("kill_race_alive", 32'(alive[idx]), 32'd0);
            check("kill_race_escape", 32'(escape), 32'd0);
            check("kill_race_cnt", 32'(escape_cnt), 32'(cnt_before));
        end

        // Fill every slot, hold without steps, then free slot 2
        for (int t = 0; t < 3000 && !model_full(); t++) cycle(1'b1, 1'b0, 0);
        got = model_full();
        check("full_reached", 32'(got), 32'd1);
        repeat (3) cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, 2);
        for (int t = 0; t < 40 && !m_alive[2]; t++) cycle(1'b1, 1'b0, 0);

        // Mid-run asynchronous reset with alive = 1011
        for (int t = 0; t < 3000 && !model_full(); t++) cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 2);
        check("pre_rst_alive", 32'(alive), 32'hB);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pos", 32'(pos), 32'd0);
        check("async_rst_alive", 32'(alive), 32'd0);
        check("async_rst_escape", 32'(escape), 32'd0);
        check("async_rst_cnt", 32'(escape_cnt), 32'd0);
        check("async_rst_occ", 32'(occupancy), 32'd0);
        model_reset();
        prev_alive  = 4'd0;
        steps_since = 1000;
        @(negedge clk) rst = 1'b1;

        // Random traffic with occasional kills
        for (int t = 0; t < 500; t++) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)));
        end

        // Back-to-back steps until the escape total saturates
        for (int t = 0; t < 6000 && (m_total_esc < 320 || m_cnt < 255); t++) cycle(1'b1, 1'b0, 0);
        check("sat_cnt", 32'(escape_cnt), 32'd255);
        for (int t = 0; t < 40 && !m_esc; t++) cycle(1'b1, 1'b0, 0);
        check("sat_escape_pulse", 32'(escape), 32'd1);
        check("sat_cnt_hold", 32'(escape_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
